// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA output stage: colour-reduction modes,
// the 2x2 ordered-dither table and a saturating adder.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC  = 2'd0,
        MODE_ROUND  = 2'd1,
        MODE_DITHER = 2'd2,
        MODE_TPAT   = 2'd3
    } mode_e;

    // Wide enough for any supported input colour width.
    localparam int SAT_W = 16;

    function automatic logic [1:0] bayer2x2(input logic x0, input logic y0);
        logic [1:0] b;
        case ({x0, y0})
            2'b00:   b = 2'd0;
            2'b10:   b = 2'd2;
            2'b01:   b = 2'd3;
            default: b = 2'd1;
        endcase
        return b;
    endfunction

    // Adds two values and clamps the result to the largest w-bit number.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned      w);
        logic [SAT_W:0]   sum;
        logic [SAT_W-1:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = {SAT_W{1'b1}} >> (SAT_W - int'(w));
        return (sum > {1'b0, lim}) ? lim : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/vga_chan_quant.sv
// Combinational colour reduction for one channel: truncate, round or
// ordered dither from IN_W down to OUT_W bits, saturating instead of wrapping.
module vga_chan_quant
    import vga_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 5
) (
    input  logic [IN_W-1:0]  value,
    input  mode_e            mode_q,
    input  logic [1:0]       bayer_b,
    output logic [OUT_W-1:0] q
);

    localparam int D = IN_W - OUT_W;

    generate
        if (D == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = ^{mode_q, bayer_b};
            assign q = value;
        end else begin : g_quant
            logic [SAT_W-1:0] round_add;
            logic [SAT_W-1:0] dith_add;
            logic [SAT_W-1:0] add_v;
            logic [SAT_W-1:0] sum_v;

            assign round_add = SAT_W'(1) << (D - 1);

            // With a single dropped bit there is no room for a 2-bit threshold.
            if (D >= 2) begin : g_dith
                assign dith_add = SAT_W'(bayer_b) << (D - 2);
            end else begin : g_dith_round
                logic unused_ok;
                assign unused_ok = ^bayer_b;
                assign dith_add  = round_add;
            end

            always_comb begin
                add_v = '0;
                case (mode_q)
                    MODE_ROUND:  add_v = round_add;
                    MODE_DITHER: add_v = dith_add;
                    default:     add_v = '0;
                endcase
            end

            assign sum_v = sat_add(SAT_W'(value), add_v, IN_W);
            assign q     = OUT_W'(sum_v >> D);
        end
    endgenerate

endmodule

// File: rtl/vga_out_stage.sv
// VGA output stage: aligns sync/de with the colour path, reduces colour depth,
// optionally shows an 8-bar test pattern and registers everything to the pins.
module vga_out_stage
    import vga_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int R_W       = 5,
    parameter int G_W       = 6,
    parameter int B_W       = 5,
    parameter int SYNC_DLY  = 0,
    parameter int SYNC_ACT  = 0,
    parameter int CNT_W     = 12,
    parameter int BAR_SHIFT = 7
) (
    input  logic            pix_clk,
    input  logic            pix_rstn,
    input  logic [1:0]      mode,
    input  logic            in_hsync,
    input  logic            in_vsync,
    input  logic            in_de,
    input  logic [IN_W-1:0] in_r,
    input  logic [IN_W-1:0] in_g,
    input  logic [IN_W-1:0] in_b,
    output logic            vga_hsync,
    output logic            vga_vsync,
    output logic            vga_de,
    output logic [R_W-1:0]  vga_r,
    output logic [G_W-1:0]  vga_g,
    output logic [B_W-1:0]  vga_b,
    output logic            frame_start
);

    localparam logic SYNC_ON = (SYNC_ACT != 0);

    logic [2:0] sync_raw;
    logic [2:0] sync_dly;
    logic       d_hs;
    logic       d_vs;
    logic       d_de;

    assign sync_raw = {in_hsync, in_vsync, in_de};

    generate
        if (SYNC_DLY == 0) begin : g_nodly
            assign sync_dly = sync_raw;
        end else begin : g_dly
            logic [3*SYNC_DLY-1:0] dly_q;
            logic [3*SYNC_DLY-1:0] dly_d;

            always_comb begin
                dly_d      = dly_q << 3;
                dly_d[2:0] = sync_raw;
            end

            always_ff @(posedge pix_clk or negedge pix_rstn) begin
                if (!pix_rstn) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign sync_dly = dly_q[3*SYNC_DLY-1 -: 3];
        end
    endgenerate

    assign {d_hs, d_vs, d_de} = sync_dly;

    // Pixel position, frame parity and the per-frame mode latch.
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             frame_q, frame_d;
    mode_e            mode_q, mode_d;
    logic             de_prev_q;
    logic             vs_prev_q;
    logic             vs_edge;
    logic             de_fall;

    always_comb begin
        vs_edge = (d_vs == SYNC_ON) && (vs_prev_q != SYNC_ON);
        de_fall = de_prev_q && !d_de;
        x_d     = d_de ? x_q + CNT_W'(1) : '0;
        y_d     = y_q;
        if (vs_edge) begin
            y_d = '0;
        end else if (de_fall) begin
            y_d = y_q + CNT_W'(1);
        end
        frame_d = frame_q ^ vs_edge;
        mode_d  = vs_edge ? mode_e'(mode) : mode_q;
    end

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            x_q       <= '0;
            y_q       <= '0;
            frame_q   <= 1'b0;
            mode_q    <= MODE_TRUNC;
            de_prev_q <= 1'b0;
            vs_prev_q <= SYNC_ON;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            frame_q   <= frame_d;
            mode_q    <= mode_d;
            de_prev_q <= d_de;
            vs_prev_q <= d_vs;
        end
    end

    // Odd frames shift the dither threshold by half its range so the pattern inverts.
    logic [1:0]     bayer_b;
    logic [2:0]     bar_idx;
    logic [R_W-1:0] r_quant;
    logic [G_W-1:0] g_quant;
    logic [B_W-1:0] b_quant;

    assign bayer_b = bayer2x2(x_q[0], y_q[0]) + {frame_q, 1'b0};
    assign bar_idx = x_q[BAR_SHIFT+2 -: 3];

    vga_chan_quant #(.IN_W(IN_W), .OUT_W(R_W)) u_quant_r (
        .value   (in_r),
        .mode_q  (mode_q),
        .bayer_b (bayer_b),
        .q       (r_quant)
    );

    vga_chan_quant #(.IN_W(IN_W), .OUT_W(G_W)) u_quant_g (
        .value   (in_g),
        .mode_q  (mode_q),
        .bayer_b (bayer_b),
        .q       (g_quant)
    );

    vga_chan_quant #(.IN_W(IN_W), .OUT_W(B_W)) u_quant_b (
        .value   (in_b),
        .mode_q  (mode_q),
        .bayer_b (bayer_b),
        .q       (b_quant)
    );

    logic [R_W-1:0] vga_r_q, vga_r_d;
    logic [G_W-1:0] vga_g_q, vga_g_d;
    logic [B_W-1:0] vga_b_q, vga_b_d;
    logic           vga_hsync_q;
    logic           vga_vsync_q;
    logic           vga_de_q;
    logic           frame_start_q;

    always_comb begin
        vga_r_d = '0;
        vga_g_d = '0;
        vga_b_d = '0;
        if (d_de) begin
            if (mode_q == MODE_TPAT) begin
                vga_r_d = {R_W{bar_idx[2]}};
                vga_g_d = {G_W{bar_idx[1]}};
                vga_b_d = {B_W{bar_idx[0]}};
            end else begin
                vga_r_d = r_quant;
                vga_g_d = g_quant;
                vga_b_d = b_quant;
            end
        end
    end

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            vga_hsync_q   <= ~SYNC_ON;
            vga_vsync_q   <= ~SYNC_ON;
            vga_de_q      <= 1'b0;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            vga_hsync_q   <= d_hs;
            vga_vsync_q   <= d_vs;
            vga_de_q      <= d_de;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
            frame_start_q <= vs_edge;
        end
    end

    assign vga_hsync   = vga_hsync_q;
    assign vga_vsync   = vga_vsync_q;
    assign vga_de      = vga_de_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign frame_start = frame_start_q;

endmodule
